// File: rtl/pl_dmem_pkg.sv
// Shared definitions for the pl_datamem_be data memory.
//   - Access size codes (byte / half / word / reserved).
//   - FSM state encoding for the init sweep and normal operation.
//   - dmem_misaligned(): alignment check for a given size and byte offset.
// Optional feature macro used by the top: DMEM_INIT_EN (hardware clear after reset).
package pl_dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } dmem_state_e;

    // Half must sit on an even byte, word on a multiple of four.
    function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_H:    mis = addr_lo[0];
            SZ_W:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/pl_dmem_lane_align.sv
// Combinational byte-lane steering for pl_datamem_be.
// Store side: turns size + byte offset into per-lane write enables and replicates the
//   right-justified store data onto every lane it could land in.
// Load side: picks the addressed byte/half out of the raw word and sign- or zero-extends it.
// Ports:
//   i_st_size, i_st_addr_lo, i_st_wdata -> o_st_byte_en, o_st_wdata
//   i_ld_size, i_ld_unsigned, i_ld_addr_lo, i_ld_word -> o_ld_rdata
module pl_dmem_lane_align
    import pl_dmem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_byte_en,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_byte_en = 4'b0000;
        o_st_wdata   = i_st_wdata;
        case (i_st_size)
            SZ_B: begin
                o_st_byte_en = 4'b0001 << i_st_addr_lo;
                o_st_wdata   = {4{i_st_wdata[7:0]}};
            end
            SZ_H: begin
                o_st_byte_en = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata   = {2{i_st_wdata[15:0]}};
            end
            SZ_W: begin
                o_st_byte_en = 4'b1111;
            end
            default: begin
                o_st_byte_en = 4'b0000;
            end
        endcase
    end

    always_comb begin
        w_byte     = i_ld_word[{i_ld_addr_lo, 3'b000} +: 8];
        w_half     = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        o_ld_rdata = 32'h0;
        case (i_ld_size)
            SZ_B:    o_ld_rdata = i_ld_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_ld_rdata = i_ld_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            SZ_W:    o_ld_rdata = i_ld_word;
            default: o_ld_rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/pl_datamem_be.sv
// Byte-enabled data memory for the MEM stage of the pipelined RISC-V core.
// lb/lh/lw/lbu/lhu/sb/sh/sw with a registered one-cycle read, valid/ready request port,
// and misaligned / out-of-range / reserved-size error detection.
// Optional feature: define DMEM_INIT_EN to clear every word in hardware after reset
// (DEPTH-cycle sweep with req_ready low). Without it the block is ready one edge after reset.
// Ports:
//   i_clk, i_rst                : clock, asynchronous active-high reset
//   i_req_valid / o_req_ready   : request handshake
//   i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata : request fields
//   o_rsp_valid, o_rsp_rdata, o_rsp_err : response, one cycle after accept
//   o_init_done                 : init sweep complete
module pl_datamem_be
    import pl_dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_init_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    dmem_state_e r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;
    logic          r_init_done;

    logic          r_rsp_valid;
    logic          r_err;
    logic          r_rdata_zero;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [1:0]    r_addr_lo;

    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_err;
    logic          w_accept;
    logic          w_st_ok;
    logic          w_ld_ok;
    logic          w_init;
    logic [3:0]    w_byte_en;
    logic [31:0]   w_wdata_rep;
    logic [3:0]    w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic [31:0]   w_wr_data;
    logic [31:0]   w_rword;
    logic [31:0]   w_ld_rdata;

    // Request decode. BASE_ADDR is DEPTH*4 aligned, so off[1:0] equals addr[1:0].
    assign w_off    = i_req_addr - BASE_ADDR;
    assign w_idx    = w_off[AW+1:2];
    assign w_oor    = |w_off[31:AW+2];
    assign w_err    = w_oor | (i_req_size == SZ_R) | dmem_misaligned(i_req_size, w_off[1:0]);
    assign w_accept = i_req_valid & r_ready;
    assign w_st_ok  = w_accept & i_req_we & ~w_err;
    assign w_ld_ok  = w_accept & ~i_req_we & ~w_err;
    assign w_init   = (r_state == ST_INIT);

    // Control FSM: INIT sweeps the array, IDLE accepts requests.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
`ifdef DMEM_INIT_EN
            r_state <= ST_INIT;
`else
            r_state <= ST_IDLE;
`endif
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_ready     <= 1'b1;
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    // Response registers only move on accept so rdata/err hold between responses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_rdata_zero <= 1'b1;
            r_size       <= SZ_W;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_err        <= w_err;
                r_rdata_zero <= w_err | i_req_we;
                r_size       <= i_req_size;
                r_unsigned   <= i_req_unsigned;
                r_addr_lo    <= w_off[1:0];
            end
        end
    end

    pl_dmem_lane_align u_lane_align (
        .i_st_size     (i_req_size),
        .i_st_addr_lo  (w_off[1:0]),
        .i_st_wdata    (i_req_wdata),
        .o_st_byte_en  (w_byte_en),
        .o_st_wdata    (w_wdata_rep),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_ld_addr_lo  (r_addr_lo),
        .i_ld_word     (w_rword),
        .o_ld_rdata    (w_ld_rdata)
    );

    // Write port is shared between the init sweep and accepted stores.
    always_comb begin
        w_wr_en   = 4'b0000;
        w_wr_idx  = w_idx;
        w_wr_data = w_wdata_rep;
        if (w_init) begin
            w_wr_en   = 4'b1111;
            w_wr_idx  = r_cnt;
            w_wr_data = 32'h0;
        end else if (w_st_ok) begin
            w_wr_en = w_byte_en;
        end
    end

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rbyte;

        always_ff @(posedge i_clk) begin
            if (w_wr_en[l]) begin
                r_mem[w_wr_idx] <= w_wr_data[8*l +: 8];
            end
            if (w_ld_ok) begin
                r_rbyte <= r_mem[w_idx];
            end
        end
    end

    assign w_rword = {g_lane[3].r_rbyte, g_lane[2].r_rbyte, g_lane[1].r_rbyte, g_lane[0].r_rbyte};

    assign o_req_ready = r_ready;
    assign o_init_done = r_init_done;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_err;
    assign o_rsp_rdata = r_rdata_zero ? 32'h0 : w_ld_rdata;

endmodule

// File: tb/tb_pl_datamem_be.sv
// Self-checking bench for pl_datamem_be: table of directed single requests with hold checks,
// plus hand-written sequences for reset/init, back-to-back store/load and mid-sweep reset.
module tb_pl_datamem_be;

    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0;
`ifdef DMEM_INIT_EN
    localparam int INIT_EDGES = DEPTH;
`else
    localparam int INIT_EDGES = 1;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int n_checks = 0;
    int n_err    = 0;

    pl_datamem_be #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_err      (rsp_err),
        .o_init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                       input logic ee);
        vec_t v;
        v.name = n; v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
    endtask

    // One request, response check one cycle later, then a hold check on the idle cycle after.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        chk({v.name, " ready"}, 32'(req_ready), 32'd1);
        drive(v.we, v.size, v.uns, v.addr, v.wdata);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk({v.name, " valid"}, 32'(rsp_valid), 32'd1);
        chk({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
        @(negedge clk);
        chk({v.name, " hold valid"}, 32'(rsp_valid), 32'd0);
        chk({v.name, " hold rdata"}, rsp_rdata, v.exp_rdata);
        chk({v.name, " hold err"}, 32'(rsp_err), 32'(v.exp_err));
    endtask

    // Counts edges after reset release until ready rises; no response may appear meanwhile.
    task automatic wait_ready(input string name);
        int  edges;
        logic got;
        logic saw_rsp;
        edges = 0; got = 1'b0; saw_rsp = 1'b0;
        for (int k = 0; k < 4 * DEPTH && !got; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (req_ready) got = 1'b1;
            else if (rsp_valid) saw_rsp = 1'b1;
        end
        chk({name, " ready rose"}, 32'(got), 32'd1);
        chk({name, " ready edges"}, 32'(edges), 32'(INIT_EDGES));
        chk({name, " no rsp while busy"}, 32'(saw_rsp), 32'd0);
        chk({name, " init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        #12;
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", rsp_rdata, 32'h0);
        chk("reset err", 32'(rsp_err), 32'd0);
        chk("reset init_done", 32'(init_done), 32'd0);

        // Request held across the busy window; it is accepted only once ready rises.
`ifdef DMEM_INIT_EN
        drive(1'b0, 2'b10, 1'b0, BASE + 32'h50, 32'h0);
`else
        drive(1'b1, 2'b10, 1'b0, BASE + 32'h50, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;
        wait_ready("init");
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("held req valid", 32'(rsp_valid), 32'd1);
        chk("held req rdata", rsp_rdata, 32'h0);
        chk("held req err", 32'(rsp_err), 32'd0);

        add("sw f2",     1, 2'b10, 0, BASE + 32'h50, 32'h000000f2, 32'h0, 0);
        add("lb 50",     0, 2'b00, 0, BASE + 32'h50, 32'h0, 32'hfffffff2, 0);
        add("lbu 50",    0, 2'b00, 1, BASE + 32'h50, 32'h0, 32'h000000f2, 0);
        add("lh 50",     0, 2'b01, 0, BASE + 32'h50, 32'h0, 32'h000000f2, 0);
        add("lw u 50",   0, 2'b10, 1, BASE + 32'h50, 32'h0, 32'h000000f2, 0);
        add("sw ff 5c",  1, 2'b10, 0, BASE + 32'h5c, 32'hffffffff, 32'h0, 0);
        add("sb 5d",     1, 2'b00, 0, BASE + 32'h5d, 32'haaaaaa12, 32'h0, 0);
        add("sh 5e",     1, 2'b01, 0, BASE + 32'h5e, 32'h5555abcd, 32'h0, 0);
        add("lw 5c",     0, 2'b10, 0, BASE + 32'h5c, 32'h0, 32'habcd12ff, 0);
        add("lb 5d",     0, 2'b00, 0, BASE + 32'h5d, 32'h0, 32'h00000012, 0);
        add("lb 5f",     0, 2'b00, 0, BASE + 32'h5f, 32'h0, 32'hffffffab, 0);
        add("lh 5e",     0, 2'b01, 0, BASE + 32'h5e, 32'h0, 32'hffffabcd, 0);
        add("lhu 5e",    0, 2'b01, 1, BASE + 32'h5e, 32'h0, 32'h0000abcd, 0);
        add("sw 58",     1, 2'b10, 0, BASE + 32'h58, 32'h11223344, 32'h0, 0);
        add("lh 51 mis", 0, 2'b01, 0, BASE + 32'h51, 32'h0, 32'h0, 1);
        add("sw 5a mis", 1, 2'b10, 0, BASE + 32'h5a, 32'h00000001, 32'h0, 1);
        add("sh 59 mis", 1, 2'b01, 0, BASE + 32'h59, 32'h00007777, 32'h0, 1);
        add("lw 58 kept", 0, 2'b10, 0, BASE + 32'h58, 32'h0, 32'h11223344, 0);
        add("sw 00",     1, 2'b10, 0, BASE + 32'h00, 32'hcafef00d, 32'h0, 0);
        add("sw oor",    1, 2'b10, 0, BASE + DEPTH * 4, 32'hdeadbeef, 32'h0, 1);
        add("lw oor",    0, 2'b10, 0, BASE + DEPTH * 4, 32'h0, 32'h0, 1);
        add("st sz11",   1, 2'b11, 0, BASE + 32'h00, 32'h0, 32'h0, 1);
        add("ld sz11",   0, 2'b11, 0, BASE + 32'h00, 32'h0, 32'h0, 1);
        add("lw 00 kept", 0, 2'b10, 0, BASE + 32'h00, 32'h0, 32'hcafef00d, 0);
        add("sw last",   1, 2'b10, 0, BASE + DEPTH * 4 - 4, 32'h13579bdf, 32'h0, 0);
        add("lw last",   0, 2'b10, 0, BASE + DEPTH * 4 - 4, 32'h0, 32'h13579bdf, 0);
        add("lw neg",    0, 2'b10, 0, BASE - 32'h4, 32'h0, 32'h0, 1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back store then load of the same word.
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, BASE + 32'h58, 32'h00000200);
        @(posedge clk);
        #1 drive(1'b0, 2'b10, 1'b0, BASE + 32'h58, 32'h0);
        @(negedge clk);
        chk("b2b st valid", 32'(rsp_valid), 32'd1);
        chk("b2b st rdata", rsp_rdata, 32'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b ld valid", 32'(rsp_valid), 32'd1);
        chk("b2b ld rdata", rsp_rdata, 32'h00000200);
        chk("b2b ld err", 32'(rsp_err), 32'd0);

`ifdef DMEM_INIT_EN
        // Dirty a word beyond the restart point, then reset mid-sweep at cnt=5.
        run_vec('{"sw 40", 1'b1, 2'b10, 1'b0, BASE + 32'h40, 32'h5a5a5a5a, 32'h0, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2 ready", 32'(req_ready), 32'd0);
        chk("rst2 init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid rst ready", 32'(req_ready), 32'd0);
        chk("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("restart");
        run_vec('{"lw 40 clr", 1'b0, 2'b10, 1'b0, BASE + 32'h40, 32'h0, 32'h0, 1'b0});
        run_vec('{"lw 58 clr", 1'b0, 2'b10, 1'b0, BASE + 32'h58, 32'h0, 32'h0, 1'b0});
`else
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2 ready", 32'(req_ready), 32'd0);
        chk("rst2 init_done", 32'(init_done), 32'd0);
        chk("rst2 rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("restart");
        run_vec('{"sw 44", 1'b1, 2'b10, 1'b0, BASE + 32'h44, 32'h0badf00d, 32'h0, 1'b0});
        run_vec('{"lhu 46", 1'b0, 2'b01, 1'b1, BASE + 32'h46, 32'h0, 32'h00000bad, 1'b0});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
